// File: rtl/bure_pkg.sv
// bure_pkg: shared definitions for the memory stage.
//   - funct3 encodings for load/store access size and sign
//   - mem_state_t: memory-stage FSM state
//   - mem_fault(): decides whether a memory op is illegal or misaligned
package bure_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_REQ        = 2'd1,
      ST_WAIT_RDATA = 2'd2
   } mem_state_t;

   // Unsigned variants exist only for loads, so a store using them is illegal.
   function automatic logic mem_fault(input logic       is_store,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
      logic f;
      case (funct3)
         F3_B:    f = 1'b0;
         F3_H:    f = addr_lo[0];
         F3_W:    f = |addr_lo;
         F3_BU:   f = is_store;
         F3_HU:   f = is_store | addr_lo[0];
         default: f = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/bure_lsu_align.sv
// bure_lsu_align: combinational lane steering for the data bus.
//   funct3     in  3   access size/sign
//   addr_lo    in  2   byte offset within the word
//   store_data in  32  raw store operand
//   rdata      in  32  word returned by the bus
//   be         out 4   byte enables
//   wdata      out 32  store data replicated across lanes
//   load_data  out 32  addressed byte/half, sign- or zero-extended
module bure_lsu_align
   import bure_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << addr_lo;
            wdata = {2{store_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = store_data;
         end
      endcase

      case (funct3)
         F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
         F3_BU:   load_data = {24'd0, byte_sel};
         F3_HU:   load_data = {16'd0, half_sel};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/bure_stage_mem.sv
// bure_stage_mem: memory stage between EX and writeback.
//   i_clk, i_rst        clock, async active-high reset
//   i_ex_* / o_ex_ready EX result handshake and fields
//   o_dmem_* / i_dmem_* data bus request/grant and read-data return
//   o_wb_*              one-cycle writeback pulse with data, rd, we, fault
//
// state       | meaning
// ST_IDLE     | ready for an EX result; non-memory and faulting ops retire here
// ST_REQ      | bus request held until grant
// ST_WAIT_RDATA | load granted, waiting for read data
module bure_stage_mem
   import bure_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,

   input  logic                  i_ex_valid,
   output logic                  o_ex_ready,
   input  logic [DATA_WIDTH-1:0] i_ex_alu_data,
   input  logic [DATA_WIDTH-1:0] i_ex_rs2_data,
   input  logic [4:0]            i_ex_rd_addr,
   input  logic                  i_ex_rd_we,
   input  logic                  i_ex_is_load,
   input  logic                  i_ex_is_store,
   input  logic [2:0]            i_ex_funct3,

   output logic                  o_dmem_req,
   input  logic                  i_dmem_gnt,
   output logic                  o_dmem_we,
   output logic [ADDR_WIDTH-1:0] o_dmem_addr,
   output logic [3:0]            o_dmem_be,
   output logic [DATA_WIDTH-1:0] o_dmem_wdata,
   input  logic                  i_dmem_rvalid,
   input  logic [DATA_WIDTH-1:0] i_dmem_rdata,

   output logic                  o_wb_valid,
   output logic [4:0]            o_wb_rd_addr,
   output logic                  o_wb_we,
   output logic [DATA_WIDTH-1:0] o_wb_data,
   output logic                  o_wb_fault
);

   mem_state_t            state;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] rs2_q;
   logic                  rd_we_q;
   logic                  is_store_q;
   logic [2:0]            funct3_q;

   logic [3:0]            be_c;
   logic [31:0]           wdata_c;
   logic [31:0]           load_data_c;

   logic                  ex_is_mem;
   logic                  ex_fault;

   assign ex_is_mem = i_ex_is_load | i_ex_is_store;
   assign ex_fault  = mem_fault(i_ex_is_store, i_ex_funct3, i_ex_alu_data[1:0]);

   // Lane steering works from the captured fields so the bus stays stable while REQ waits.
   bure_lsu_align u_align (
      .funct3     (funct3_q),
      .addr_lo    (addr_q[1:0]),
      .store_data (rs2_q),
      .rdata      (i_dmem_rdata),
      .be         (be_c),
      .wdata      (wdata_c),
      .load_data  (load_data_c)
   );

   assign o_ex_ready   = (state == ST_IDLE);
   assign o_dmem_req   = (state == ST_REQ);
   assign o_dmem_we    = (state == ST_REQ) & is_store_q;
   assign o_dmem_be    = (state == ST_REQ) ? be_c : 4'b0000;
   assign o_dmem_addr  = ADDR_WIDTH'({addr_q[31:2], 2'b00});
   assign o_dmem_wdata = wdata_c;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         addr_q       <= '0;
         rs2_q        <= '0;
         rd_we_q      <= 1'b0;
         is_store_q   <= 1'b0;
         funct3_q     <= 3'b000;
         o_wb_valid   <= 1'b0;
         o_wb_rd_addr <= 5'd0;
         o_wb_we      <= 1'b0;
         o_wb_data    <= '0;
         o_wb_fault   <= 1'b0;
      end else begin
         o_wb_valid <= 1'b0;
         o_wb_we    <= 1'b0;
         o_wb_fault <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (i_ex_valid) begin
                  addr_q       <= i_ex_alu_data;
                  rs2_q        <= i_ex_rs2_data;
                  rd_we_q      <= i_ex_rd_we;
                  is_store_q   <= i_ex_is_store;
                  funct3_q     <= i_ex_funct3;
                  o_wb_rd_addr <= i_ex_rd_addr;
                  if (!ex_is_mem) begin
                     o_wb_valid <= 1'b1;
                     o_wb_we    <= i_ex_rd_we;
                     o_wb_data  <= i_ex_alu_data;
                  end else if (ex_fault) begin
                     o_wb_valid <= 1'b1;
                     o_wb_fault <= 1'b1;
                     o_wb_data  <= '0;
                  end else begin
                     state <= ST_REQ;
                  end
               end
            end

            ST_REQ: begin
               // Read data is only looked at from WAIT_RDATA onward, so an
               // rvalid coincident with gnt is dropped.
               if (i_dmem_gnt) begin
                  if (is_store_q) begin
                     state      <= ST_IDLE;
                     o_wb_valid <= 1'b1;
                     o_wb_data  <= '0;
                  end else begin
                     state <= ST_WAIT_RDATA;
                  end
               end
            end

            ST_WAIT_RDATA: begin
               if (i_dmem_rvalid) begin
                  state      <= ST_IDLE;
                  o_wb_valid <= 1'b1;
                  o_wb_we    <= rd_we_q;
                  o_wb_data  <= load_data_c;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bure_stage_mem.sv
module tb_bure_stage_mem;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_ex_valid;
   logic        o_ex_ready;
   logic [31:0] i_ex_alu_data;
   logic [31:0] i_ex_rs2_data;
   logic [4:0]  i_ex_rd_addr;
   logic        i_ex_rd_we;
   logic        i_ex_is_load;
   logic        i_ex_is_store;
   logic [2:0]  i_ex_funct3;
   logic        o_dmem_req;
   logic        i_dmem_gnt;
   logic        o_dmem_we;
   logic [31:0] o_dmem_addr;
   logic [3:0]  o_dmem_be;
   logic [31:0] o_dmem_wdata;
   logic        i_dmem_rvalid;
   logic [31:0] i_dmem_rdata;
   logic        o_wb_valid;
   logic [4:0]  o_wb_rd_addr;
   logic        o_wb_we;
   logic [31:0] o_wb_data;
   logic        o_wb_fault;

   bure_stage_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_ex_valid    (i_ex_valid),
      .o_ex_ready    (o_ex_ready),
      .i_ex_alu_data (i_ex_alu_data),
      .i_ex_rs2_data (i_ex_rs2_data),
      .i_ex_rd_addr  (i_ex_rd_addr),
      .i_ex_rd_we    (i_ex_rd_we),
      .i_ex_is_load  (i_ex_is_load),
      .i_ex_is_store (i_ex_is_store),
      .i_ex_funct3   (i_ex_funct3),
      .o_dmem_req    (o_dmem_req),
      .i_dmem_gnt    (i_dmem_gnt),
      .o_dmem_we     (o_dmem_we),
      .o_dmem_addr   (o_dmem_addr),
      .o_dmem_be     (o_dmem_be),
      .o_dmem_wdata  (o_dmem_wdata),
      .i_dmem_rvalid (i_dmem_rvalid),
      .i_dmem_rdata  (i_dmem_rdata),
      .o_wb_valid    (o_wb_valid),
      .o_wb_rd_addr  (o_wb_rd_addr),
      .o_wb_we       (o_wb_we),
      .o_wb_data     (o_wb_data),
      .o_wb_fault    (o_wb_fault)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [4:0]  rd;
      logic        we;
      logic [31:0] data;
      logic        chk_data;
      logic        fault;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   errors  = 0;
   int   checks  = 0;
   int   wb_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push(input logic [4:0] rd, input logic we, input logic [31:0] data,
                       input logic chk_data, input logic fault);
      exp_t x;
      x.rd = rd; x.we = we; x.data = data; x.chk_data = chk_data; x.fault = fault;
      sb_q.push_back(x);
   endtask

   // Scoreboard monitor: every writeback pulse must match the oldest expectation.
   always @(negedge i_clk) begin
      if (i_rst === 1'b0) begin
         if (o_wb_valid === 1'b1) begin
            wb_seen++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wb_unexpected: got wb_valid=1 data=0x%08h expected no writeback", o_wb_data);
            end else begin
               e = sb_q.pop_front();
               chk("wb_rd", 32'(o_wb_rd_addr), 32'(e.rd));
               chk("wb_we", 32'(o_wb_we), 32'(e.we));
               chk("wb_fault", 32'(o_wb_fault), 32'(e.fault));
               if (e.chk_data) chk("wb_data", o_wb_data, e.data);
            end
         end else if (o_wb_valid === 1'b0) begin
            chk("fault_without_valid", 32'(o_wb_fault), 32'd0);
         end else begin
            chk("wb_valid_known", 32'(o_wb_valid), 32'd0);
         end
      end
   end

   // Issue one EX result; called 1 time unit after a rising edge with the stage idle.
   task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic we, input logic ld, input logic st, input logic [2:0] f3);
      chk("issue_ready", 32'(o_ex_ready), 32'd1);
      i_ex_valid    = 1'b1;
      i_ex_alu_data = alu;
      i_ex_rs2_data = rs2;
      i_ex_rd_addr  = rd;
      i_ex_rd_we    = we;
      i_ex_is_load  = ld;
      i_ex_is_store = st;
      i_ex_funct3   = f3;
      @(posedge i_clk); #1;
      i_ex_valid    = 1'b0;
      i_ex_is_load  = 1'b0;
      i_ex_is_store = 1'b0;
   endtask

   task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                           input int delay, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      int n = 0;
      push(5'd3, 1'b0, 32'd0, 1'b0, 1'b0);
      issue(addr, rs2, 5'd3, 1'b1, 1'b0, 1'b1, f3);
      i_dmem_gnt = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge i_clk);
         if (o_dmem_req !== 1'b1) break;
         n++;
         chk("st_addr", o_dmem_addr, {addr[31:2], 2'b00});
         chk("st_be", 32'(o_dmem_be), 32'(exp_be));
         chk("st_wdata", o_dmem_wdata, exp_wdata);
         chk("st_we", 32'(o_dmem_we), 32'd1);
         if (n == delay + 1) break;
      end
      i_dmem_gnt = 1'b1;
      @(posedge i_clk); #1;
      i_dmem_gnt = 1'b0;
      chk("st_req_cycles", 32'(n), 32'(delay + 1));
      chk("st_wb_after_gnt", 32'(o_wb_valid), 32'd1);
      chk("st_req_drop", 32'(o_dmem_req), 32'd0);
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_data);
      push(5'd7, 1'b1, exp_data, 1'b1, 1'b0);
      issue(addr, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, f3);
      chk("ld_req", 32'(o_dmem_req), 32'd1);
      chk("ld_we", 32'(o_dmem_we), 32'd0);
      chk("ld_be", 32'(o_dmem_be), 32'(exp_be));
      chk("ld_addr", o_dmem_addr, {addr[31:2], 2'b00});
      // rvalid together with gnt carries junk that must not be consumed
      i_dmem_gnt    = 1'b1;
      i_dmem_rvalid = 1'b1;
      i_dmem_rdata  = 32'hDEADBEEF;
      @(posedge i_clk); #1;
      i_dmem_gnt    = 1'b0;
      i_dmem_rvalid = 1'b0;
      chk("ld_no_early_wb", 32'(o_wb_valid), 32'd0);
      chk("ld_req_drop", 32'(o_dmem_req), 32'd0);
      @(posedge i_clk); #1;
      i_dmem_rvalid = 1'b1;
      i_dmem_rdata  = rdata;
      @(posedge i_clk); #1;
      i_dmem_rvalid = 1'b0;
      chk("ld_wb_valid", 32'(o_wb_valid), 32'd1);
      chk("ld_ready", 32'(o_ex_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen0;
      i_rst = 1'b1;
      i_ex_valid = 1'b0; i_ex_alu_data = '0; i_ex_rs2_data = '0; i_ex_rd_addr = '0;
      i_ex_rd_we = 1'b0; i_ex_is_load = 1'b0; i_ex_is_store = 1'b0; i_ex_funct3 = '0;
      i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
      #2;
      chk("rst_ready", 32'(o_ex_ready), 32'd1);
      chk("rst_req", 32'(o_dmem_req), 32'd0);
      chk("rst_we", 32'(o_dmem_we), 32'd0);
      chk("rst_be", 32'(o_dmem_be), 32'd0);
      chk("rst_addr", o_dmem_addr, 32'd0);
      chk("rst_wdata", o_dmem_wdata, 32'd0);
      chk("rst_wb_valid", 32'(o_wb_valid), 32'd0);
      chk("rst_wb_we", 32'(o_wb_we), 32'd0);
      chk("rst_wb_fault", 32'(o_wb_fault), 32'd0);
      chk("rst_wb_data", o_wb_data, 32'd0);
      chk("rst_wb_rd", 32'(o_wb_rd_addr), 32'd0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      // ALU op
      push(5'd5, 1'b1, 32'h1234, 1'b1, 1'b0);
      issue(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
      chk("alu_wb_valid", 32'(o_wb_valid), 32'd1);
      chk("alu_no_req", 32'(o_dmem_req), 32'd0);
      @(posedge i_clk); #1;

      // Stores
      do_store(3'b000, 32'h1003, 32'h000000AB, 2, 4'b1000, 32'hABABABAB);
      do_store(3'b001, 32'h1002, 32'h1234ABCD, 0, 4'b1100, 32'hABCDABCD);
      do_store(3'b010, 32'h1008, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D);

      // Loads
      do_load(3'b000, 32'h2001, 32'h00008000, 4'b0010, 32'hFFFFFF80);
      do_load(3'b100, 32'h2001, 32'h00008000, 4'b0010, 32'h00000080);
      do_load(3'b001, 32'h2002, 32'h80017F00, 4'b1100, 32'hFFFF8001);
      do_load(3'b101, 32'h2002, 32'h80017F00, 4'b1100, 32'h00008001);
      do_load(3'b010, 32'h2004, 32'h89ABCDEF, 4'b1111, 32'h89ABCDEF);

      // Faulting ops: misaligned LW, illegal load funct3, unsigned store
      push(5'd9, 1'b0, 32'd0, 1'b0, 1'b1);
      issue(32'h2002, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010);
      chk("mis_wb_valid", 32'(o_wb_valid), 32'd1);
      chk("mis_no_req", 32'(o_dmem_req), 32'd0);
      @(posedge i_clk); #1;
      push(5'd10, 1'b0, 32'd0, 1'b0, 1'b1);
      issue(32'h2000, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b011);
      chk("ill_ld_no_req", 32'(o_dmem_req), 32'd0);
      @(posedge i_clk); #1;
      push(5'd11, 1'b0, 32'd0, 1'b0, 1'b1);
      issue(32'h2000, 32'h55, 5'd11, 1'b0, 1'b0, 1'b1, 3'b100);
      chk("ill_st_no_req", 32'(o_dmem_req), 32'd0);
      @(posedge i_clk); #1;

      // Reset while waiting for read data; late rvalid must be ignored
      issue(32'h3000, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 3'b010);
      i_dmem_gnt = 1'b1;
      @(posedge i_clk); #1;
      i_dmem_gnt = 1'b0;
      chk("rw_waiting", 32'(o_ex_ready), 32'd0);
      seen0 = wb_seen;
      #2 i_rst = 1'b1;
      #1;
      chk("rw_ready_in_rst", 32'(o_ex_ready), 32'd1);
      chk("rw_req_in_rst", 32'(o_dmem_req), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      i_dmem_rvalid = 1'b1;
      i_dmem_rdata  = 32'h11111111;
      @(posedge i_clk); #1;
      i_dmem_rvalid = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rw_no_wb", 32'(wb_seen - seen0), 32'd0);
      chk("rw_ready_after", 32'(o_ex_ready), 32'd1);

      // Back-to-back ALU ops
      for (int i = 0; i < 4; i++) begin
         chk("b2b_ready", 32'(o_ex_ready), 32'd1);
         i_ex_valid    = 1'b1;
         i_ex_alu_data = 32'h100 + 32'(i);
         i_ex_rd_addr  = 5'(i + 1);
         i_ex_rd_we    = 1'b1;
         i_ex_is_load  = 1'b0;
         i_ex_is_store = 1'b0;
         push(5'(i + 1), 1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
         @(posedge i_clk); #1;
         chk("b2b_wb_valid", 32'(o_wb_valid), 32'd1);
      end
      i_ex_valid = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
